// File: rtl/inst_loader_if.sv
// Instruction-loader bus: load request, beat stream and RAM write port / CPU control.
interface inst_loader_if #(parameter int DEPTH_LOG2 = 10);
   logic                  start_i;
   logic [DEPTH_LOG2:0]   len_i;
   logic [31:0]           data_i;
   logic                  data_valid_i;
   logic                  data_ready_o;
   logic                  ram_ce_o;
   logic                  ram_we_o;
   logic [31:0]           ram_addr_o;
   logic [31:0]           ram_data_o;
   logic                  cpu_rst_o;
   logic                  busy_o;
   logic                  done_o;
   logic                  err_o;

   // Image source / controller side
   modport master (
      output start_i, len_i, data_i, data_valid_i,
      input  data_ready_o, ram_ce_o, ram_we_o, ram_addr_o, ram_data_o,
             cpu_rst_o, busy_o, done_o, err_o
   );

   // Loader side
   modport slave (
      input  start_i, len_i, data_i, data_valid_i,
      output data_ready_o, ram_ce_o, ram_we_o, ram_addr_o, ram_data_o,
             cpu_rst_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/inst_loader.sv
// Instruction RAM loader: streams words into consecutive RAM addresses while
// holding the CPU in reset, then releases the CPU once the image is complete.
module inst_loader #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0
) (
   input logic          clk,
   input logic          rst,
   inst_loader_if.slave bus
);
   localparam int            LW      = DEPTH_LOG2 + 1;
   localparam logic [LW-1:0] MAX_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [LW-1:0] ONE     = LW'(1);

   typedef enum logic [1:0] {HOLD, LOAD, FINISH, RUN} state_t;

   state_t        state, state_nxt;
   logic [LW-1:0] count;     // one bit wider than the address so a full image fits
   logic [LW-1:0] len_q;

   logic idle, len_bad, len_zero, beat, last;

   assign idle     = (state == HOLD) || (state == RUN);
   assign len_bad  = bus.len_i > MAX_LEN;
   assign len_zero = bus.len_i == '0;
   assign beat     = bus.data_valid_i && (state == LOAD);
   assign last     = beat && (count == len_q - ONE);

   assign bus.data_ready_o = (state == LOAD);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= HOLD;
      else     state <= state_nxt;
   end

   // Next-state decode; start requests are only honoured while idle
   always_comb begin
      state_nxt = state;
      case (state)
         HOLD, RUN: if (bus.start_i && !len_bad) state_nxt = len_zero ? FINISH : LOAD;
         LOAD:      if (last) state_nxt = FINISH;
         FINISH:    state_nxt = RUN;
         default:   state_nxt = HOLD;
      endcase
   end

   // Registered outputs: RAM write one cycle after each accepted beat, CPU reset, status
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ram_ce_o   <= 1'b0;
         bus.ram_we_o   <= 1'b0;
         bus.ram_addr_o <= '0;
         bus.ram_data_o <= '0;
         bus.cpu_rst_o  <= 1'b1;
         bus.busy_o     <= 1'b0;
         bus.done_o     <= 1'b0;
         bus.err_o      <= 1'b0;
         count          <= '0;
         len_q          <= '0;
      end else begin
         bus.ram_ce_o <= beat;
         bus.ram_we_o <= beat;
         bus.busy_o   <= (state_nxt == LOAD);
         bus.done_o   <= (state_nxt == FINISH);
         if (beat) begin
            bus.ram_addr_o <= BASE_ADDR + (32'(count) << 2);
            bus.ram_data_o <= bus.data_i;
            count          <= count + ONE;
         end
         if (idle && bus.start_i) begin
            bus.err_o <= len_bad;
            if (!len_bad && !len_zero) begin
               bus.cpu_rst_o <= 1'b1;
               len_q         <= bus.len_i;
               count         <= '0;
            end
         end else if (state == FINISH) begin
            bus.cpu_rst_o <= 1'b0;
         end
      end
   end
endmodule
